// File: rtl/neonpixel_frame_sequencer.sv
// Neonpixel frame sequencer: walks pixel RAM and streams one WS2812 frame.
// Define NEONPIXEL_SEQ_LOOP_EN to add the loop input for continuous refresh.
module neonpixel_frame_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int PIX_W        = 24,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef NEONPIXEL_SEQ_LOOP_EN
    input  logic              loop,
`endif
    input  logic [ADDR_W:0]   num_pixels,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              pix_ready,
    input  logic              ser_idle
);

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        PRESENT,
        DRAIN,
        LATCH,
        DONE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_inc;
    logic [ADDR_W:0] count;
    logic [LW-1:0]   latch_cnt;
    logic            xfer;
    logic            last;
    logic            rerun;
    logic            load_latch;

    assign idx_inc = idx + 1'b1;
    assign xfer    = pix_valid & pix_ready;
    assign last    = (idx_inc == count);

`ifdef NEONPIXEL_SEQ_LOOP_EN
    assign rerun = loop & ~abort;
`else
    assign rerun = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = (num_pixels != '0) ? FETCH : LATCH;
                end
            end
            FETCH: begin
                state_d = abort ? LATCH : WAIT_RD;
            end
            WAIT_RD: begin
                state_d = abort ? LATCH : PRESENT;
            end
            PRESENT: begin
                if (abort) begin
                    state_d = LATCH;
                end else if (xfer) begin
                    state_d = last ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (abort || ser_idle) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (latch_cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A latch-only frame has nothing to fetch when it repeats
                if (rerun) begin
                    state_d = (count != '0) ? FETCH : LATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_latch = (state_d == LATCH) && (state != LATCH);
    assign busy       = (state != IDLE) && !((state == DONE) && !rerun);
    assign done       = (state == DONE);
    assign ram_en     = (state == FETCH);
    assign ram_addr   = idx[ADDR_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            count     <= '0;
            latch_cnt <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            // Valid tracks PRESENT exactly, so it only drops on transfer or abort
            pix_valid <= (state_d == PRESENT);
            if ((state == WAIT_RD) && (state_d == PRESENT)) begin
                pix_data <= ram_rdata;
            end
            if ((state == IDLE) && start) begin
                count <= num_pixels;
            end
            if ((state == IDLE) || (state == DONE)) begin
                idx <= '0;
            end else if ((state == PRESENT) && xfer && !abort) begin
                idx <= idx_inc;
            end
            if (load_latch) begin
                latch_cnt <= LATCH_LOAD;
            end else if ((state == LATCH) && (latch_cnt != '0)) begin
                latch_cnt <= latch_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_neonpixel_frame_sequencer.sv
// Bench for neonpixel_frame_sequencer: directed frames, queue scoreboard.
// Define NEONPIXEL_SEQ_LOOP_EN to also exercise continuous refresh.
module tb_neonpixel_frame_sequencer;

    localparam int AW = 8;
    localparam int PW = 24;
    localparam int L  = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef NEONPIXEL_SEQ_LOOP_EN
    logic          loop = 1'b0;
`endif
    logic [AW:0]   num_pixels = '0;
    logic          busy;
    logic          done;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [PW-1:0] ram_rdata = '0;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready = 1'b0;
    logic          ser_idle = 1'b1;

    neonpixel_frame_sequencer #(
        .ADDR_W(AW),
        .PIX_W(PW),
        .LATCH_CYCLES(L)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
`ifdef NEONPIXEL_SEQ_LOOP_EN
        .loop(loop),
`endif
        .num_pixels(num_pixels),
        .busy(busy),
        .done(done),
        .ram_en(ram_en),
        .ram_addr(ram_addr),
        .ram_rdata(ram_rdata),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .ser_idle(ser_idle)
    );

    always #5 clock = ~clock;

    logic [PW-1:0] ram [256];
    always @(posedge clock) if (ram_en) ram_rdata <= ram[ram_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int xfer_cnt = 0;
    int last_xfer = 0;
    int start_cyc = 0;
    int abort_cyc = 0;
    int addr_q[$];
    int data_q[$];
    int dkind_q[$];
    int doff_q[$];

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard monitor: reads, transfers and done pulses against queues
    always @(negedge clock) begin
        int e;
        int base;
        if (!reset) begin
            if (ram_en) begin
                if (addr_q.size() == 0) chk(1'b0, "unexpected_read", ram_addr, -1);
                else begin
                    e = addr_q.pop_front();
                    chk(ram_addr == e, "read_addr", ram_addr, e);
                end
            end
            if (pix_valid && pix_ready) begin
                xfer_cnt++;
                last_xfer = cyc;
                if (data_q.size() == 0) chk(1'b0, "unexpected_xfer", pix_data, -1);
                else begin
                    e = data_q.pop_front();
                    chk(pix_data == e, "xfer_data", pix_data, e);
                end
            end
            if (done) begin
                if (doff_q.size() == 0) chk(1'b0, "unexpected_done", cyc, -1);
                else begin
                    e = dkind_q.pop_front();
                    base = (e == 0) ? last_xfer : (e == 1) ? start_cyc : abort_cyc;
                    e = base + doff_q.pop_front();
                    chk(cyc == e, "done_cycle", cyc, e);
                end
            end
        end
    end

    task automatic expect_frame(input int nread, input int nxfer, input int kind, input int off);
        for (int i = 0; i < nread; i++) addr_q.push_back(i);
        for (int i = 0; i < nxfer; i++) data_q.push_back(i + 1);
        if (kind >= 0) begin
            dkind_q.push_back(kind);
            doff_q.push_back(off);
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clock);
        #1;
        start = 1'b1;
        num_pixels = n[AW:0];
        start_cyc = cyc;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        do begin
            @(posedge clock);
            #1;
            k++;
        end while (!pix_valid && k < 200);
        if (!pix_valid) chk(1'b0, nm, k, 200);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!done && k < 3000);
        chk(done, nm, k, 3000);
    endtask

    task automatic drained(input string nm);
        repeat (3) @(negedge clock);
        chk(addr_q.size() + data_q.size() + doff_q.size() == 0, nm,
            addr_q.size() + data_q.size() + doff_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = PW'(i + 1);
        #1 reset = 1'b1;
        #1;
        chk({busy, done, ram_en, pix_valid} == 4'b0 && ram_addr == 0 && pix_data == 0,
            "reset_outputs", {busy, done, ram_en, pix_valid}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // 1: four pixels, serializer always ready
        pix_ready = 1'b1;
        expect_frame(4, 4, 0, L + 2);
        do_start(4);
        chk(busy, "busy_after_start", busy, 1);
        wait_done("t1_done_seen");
        drained("t1_drained");

        // 2: stall pixel 1 for ten cycles
        pix_ready = 1'b0;
        expect_frame(3, 3, 0, L + 2);
        do_start(3);
        wait_valid("t2_pix0_timeout");
        pix_ready = 1'b1;
        @(posedge clock);
        #1 pix_ready = 1'b0;
        wait_valid("t2_pix1_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk(pix_valid && !ram_en && pix_data == 2, "t2_stall_hold", pix_data, 2);
        end
        @(posedge clock);
        #1 pix_ready = 1'b1;
        wait_done("t2_done_seen");
        drained("t2_drained");

        // 3: latch-only frame, then a start that lands on the done cycle
        expect_frame(0, 0, 1, L + 1);
        do_start(0);
        wait_done("t3_done_seen");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk(!busy, "t3_start_on_done_ignored", busy, 0);
        drained("t3_drained");

        // 4: full 256-pixel frame, addresses 0..255 without wrap
        expect_frame(256, 256, 0, L + 2);
        do_start(256);
        wait_done("t4_done_seen");
        chk(xfer_cnt == 4 + 3 + 256, "t4_xfer_total", xfer_cnt, 263);
        drained("t4_drained");

        // 5: abort while pixel 2 of 8 is presented, with a start pulse
        xfer_cnt = 0;
        expect_frame(3, 2, 2, L + 1);
        do_start(8);
        for (int k = 0; k < 100 && xfer_cnt < 2; k++) begin
            @(posedge clock);
            #1;
        end
        pix_ready = 1'b0;
        wait_valid("t5_pix2_timeout");
        abort = 1'b1;
        start = 1'b1;
        num_pixels = 9'd5;
        abort_cyc = cyc;
        @(posedge clock);
        #1;
        abort = 1'b0;
        start = 1'b0;
        chk(!pix_valid && !ram_en, "t5_abort_clears", {pix_valid, ram_en}, 0);
        wait_done("t5_done_seen");
        repeat (2) @(negedge clock);
        chk(!busy, "t5_no_restart", busy, 0);
        drained("t5_drained");

        // 6: asynchronous reset while a pixel is presented
        expect_frame(1, 0, -1, 0);
        do_start(3);
        wait_valid("t6_pix0_timeout");
        #2 reset = 1'b1;
        #1;
        chk({busy, done, ram_en, pix_valid} == 4'b0 && ram_addr == 0 && pix_data == 0,
            "t6_async_reset", pix_data, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        drained("t6_drained");

`ifdef NEONPIXEL_SEQ_LOOP_EN
        // 7: two-pixel frame refreshed once, then released
        pix_ready = 1'b1;
        loop = 1'b1;
        expect_frame(2, 2, 0, L + 2);
        expect_frame(2, 2, 0, L + 2);
        do_start(2);
        wait_done("t7_done1_seen");
        chk(busy, "t7_busy_held", busy, 1);
        @(posedge clock);
        #1 loop = 1'b0;
        wait_done("t7_done2_seen");
        chk(!busy, "t7_busy_released", busy, 1'b0);
        drained("t7_drained");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
